// File: rtl/keypad_scan.sv
// Purpose : 4x4 matrix keypad scanner with debounce, one-cycle press pulse and held status.
// Latency : 2 sync cycles + up to 4*SCAN_DIV scan + (DEBOUNCE_CNT-1)*SCAN_DIV debounce + 1 cycle to pulse.
// Backpr. : none; outputs are free-running status, a held key never re-pulses.
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   COLLUMMN     - column sense, active-low, asynchronous to clk
//   LINE         - row drive, active-low, exactly one bit low
//   keyword      - code of last accepted key
//   flag_pressed - 0 idle, 1 new press (one-cycle), 2 held
module keypad_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] COLLUMMN,
    output logic [3:0] LINE,
    output logic [3:0] keyword,
    output logic [1:0] flag_pressed
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [2:0] {
        ST_SCAN     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_PRESSED  = 3'd2,
        ST_HELD     = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State and signals
    // ------------------------------------------------------------------
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    col_s_q, col_s_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;

    state_t        state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic [CW-1:0] rel_cnt_q, rel_cnt_d;

    logic [3:0]    line_q, line_d;
    logic [3:0]    keyword_q, keyword_d;
    logic [1:0]    flag_q, flag_d;

    logic          one_low;
    logic [1:0]    col_hit;
    logic [3:0]    col_pat;
    logic          col_rel;
    logic [CW-1:0] deb_inc;
    logic [CW-1:0] rel_inc;

    // Row/column to key code.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd10;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = 4'd11;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = 4'd12;
            4'd12:   code = 4'd14;
            4'd13:   code = 4'd0;
            4'd14:   code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Column synchronizer and scan tick
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d    = COLLUMMN;
        col_s_d    = sync1_q;
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 4'b1111;
            col_s_q    <= 4'b1111;
            tick_cnt_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            col_s_q    <= col_s_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Column decode: a key is only recognised when exactly one column is low;
    // multiple low columns are ambiguous and treated as no key.
    // ------------------------------------------------------------------
    always_comb begin
        one_low = 1'b1;
        col_hit = 2'd0;
        case (col_s_q)
            4'b1110: col_hit = 2'd0;
            4'b1101: col_hit = 2'd1;
            4'b1011: col_hit = 2'd2;
            4'b0111: col_hit = 2'd3;
            default: one_low = 1'b0;
        endcase
        col_pat = ~(4'b0001 << col_idx_q);
        col_rel = col_s_q[col_idx_q];
        deb_inc = deb_cnt_q + CNT_ONE;
        rel_inc = rel_cnt_q + CNT_ONE;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SCAN;
            row_q     <= 2'd0;
            col_idx_q <= 2'd0;
            deb_cnt_q <= '0;
            rel_cnt_q <= '0;
            line_q    <= 4'b1110;
            keyword_q <= 4'd0;
            flag_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_idx_q <= col_idx_d;
            deb_cnt_q <= deb_cnt_d;
            rel_cnt_q <= rel_cnt_d;
            line_q    <= line_d;
            keyword_q <= keyword_d;
            flag_q    <= flag_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. The row only moves while scanning; from detection
    // until release completes it stays frozen so other keys are ignored.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_idx_d = col_idx_q;
        deb_cnt_d = deb_cnt_q;
        rel_cnt_d = rel_cnt_q;
        case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (one_low) begin
                        col_idx_d = col_hit;
                        deb_cnt_d = CNT_ONE;
                        // The detection tick is itself the first matching tick.
                        state_d   = (CNT_ONE >= CNT_TARGET) ? ST_PRESSED : ST_DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (col_s_q == col_pat) begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc >= CNT_TARGET) begin
                            state_d = ST_PRESSED;
                        end
                    end else begin
                        deb_cnt_d = '0;
                        row_d     = row_q + 2'd1;
                        state_d   = ST_SCAN;
                    end
                end
            end
            ST_PRESSED: begin
                deb_cnt_d = '0;
                state_d   = ST_HELD;
            end
            ST_HELD: begin
                if (tick && col_rel) begin
                    rel_cnt_d = CNT_ONE;
                    state_d   = ST_RELEASE;
                    if (CNT_ONE >= CNT_TARGET) begin
                        rel_cnt_d = '0;
                        row_d     = row_q + 2'd1;
                        state_d   = ST_SCAN;
                    end
                end
            end
            ST_RELEASE: begin
                if (tick) begin
                    if (col_rel) begin
                        rel_cnt_d = rel_inc;
                        if (rel_inc >= CNT_TARGET) begin
                            rel_cnt_d = '0;
                            row_d     = row_q + 2'd1;
                            state_d   = ST_SCAN;
                        end
                    end else begin
                        rel_cnt_d = '0;
                        state_d   = ST_HELD;
                    end
                end
            end
            default: begin
                state_d   = ST_SCAN;
                deb_cnt_d = '0;
                rel_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, computed from the next state so they register in step
    // with the state itself.
    // ------------------------------------------------------------------
    always_comb begin
        line_d    = ~(4'b0001 << row_d);
        keyword_d = keyword_q;
        flag_d    = 2'd0;
        case (state_d)
            ST_PRESSED: begin
                flag_d    = 2'd1;
                keyword_d = key_code(row_d, col_idx_d);
            end
            ST_HELD, ST_RELEASE: flag_d = 2'd2;
            default:             flag_d = 2'd0;
        endcase
    end

    assign LINE         = line_q;
    assign keyword      = keyword_q;
    assign flag_pressed = flag_q;

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] COLLUMMN;
    logic [3:0] LINE;
    logic [3:0] keyword;
    logic [1:0] flag_pressed;
    logic [15:0] keys = '0;   // bit r*4+c = key at row r / column c held down

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .COLLUMMN     (COLLUMMN),
        .LINE         (LINE),
        .keyword      (keyword),
        .flag_pressed (flag_pressed)
    );

    // Passive keypad matrix: a held key pulls its column low when its row is driven.
    always_comb begin
        COLLUMMN = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (LINE[r] == 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c]) COLLUMMN[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n, output int pulses, output int nz, output int lchg);
        logic [3:0] prev;
        pulses = 0;
        nz     = 0;
        lchg   = 0;
        prev   = LINE;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (flag_pressed == 2'd1) pulses++;
            if (flag_pressed != 2'd0) nz++;
            if (LINE != prev) lchg++;
            prev = LINE;
        end
    endtask

    task automatic wait_flag(input logic [1:0] val, input int max, output int found);
        found = 0;
        for (int i = 0; i < max && found == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (flag_pressed == val) found = 1;
        end
    endtask

    initial begin
        int found, pulses, nz, lchg, flag_nz;
        logic [3:0] exp_line;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_line", LINE, 4'b1110);
        chk("reset_keyword", keyword, 4'd0);
        chk("reset_flag", flag_pressed, 2'd0);

        // ---------------- idle scan ----------------
        rst_n   = 1'b1;
        flag_nz = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_line = ~(4'b0001 << ((k / 4) % 4));
            chk("scan_line", LINE, exp_line);
            if (flag_pressed != 2'd0) flag_nz++;
        end
        chk("scan_flag_idle", flag_nz, 0);
        chk("scan_keyword", keyword, 4'd0);

        // ---------------- key 8 held ----------------
        keys[2*4+1] = 1'b1;
        wait_flag(2'd1, 60, found);
        chk("k8_pulse_seen", found, 1);
        chk("k8_keyword", keyword, 4'd8);
        chk("k8_line_frozen", LINE, 4'b1011);
        step(1, pulses, nz, lchg);
        chk("k8_flag_held", flag_pressed, 2'd2);
        step(100, pulses, nz, lchg);
        chk("k8_no_repulse", pulses, 0);
        chk("k8_flag_stays_nonzero", nz, 100);
        chk("k8_line_still", LINE, 4'b1011);
        keys = '0;
        step(9, pulses, nz, lchg);
        chk("k8_rel_not_yet", flag_pressed, 2'd2);
        wait_flag(2'd0, 10, found);
        chk("k8_rel_done", found, 1);
        chk("k8_rel_row_adv", LINE, 4'b0111);
        chk("k8_rel_keyword", keyword, 4'd8);

        // ---------------- key 5 bouncing ----------------
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (LINE == 4'b1101) found = 1;
        end
        chk("k5_row1_reached", found, 1);
        keys[1*4+1] = 1'b1;
        step(4, pulses, nz, lchg);
        chk("k5_bounce_detect_line", LINE, 4'b1101);
        chk("k5_bounce_flag0_a", nz, 0);
        keys[1*4+1] = 1'b0;
        step(4, pulses, nz, lchg);
        chk("k5_bounce_abort_line", LINE, 4'b1011);
        chk("k5_bounce_flag0_b", nz, 0);
        keys[1*4+1] = 1'b1;
        wait_flag(2'd1, 80, found);
        chk("k5_pulse_seen", found, 1);
        chk("k5_keyword", keyword, 4'd5);
        step(40, pulses, nz, lchg);
        chk("k5_single_pulse", pulses, 0);
        chk("k5_held", flag_pressed, 2'd2);
        keys = '0;
        wait_flag(2'd0, 30, found);
        chk("k5_released", found, 1);

        // ---------------- two columns in row 0 ----------------
        keys[0] = 1'b1;
        keys[3] = 1'b1;
        step(40, pulses, nz, lchg);
        chk("dual_no_press", nz, 0);
        chk("dual_scan_runs", (lchg >= 8), 1);
        chk("dual_keyword_kept", keyword, 4'd5);
        keys = '0;

        // ---------------- key 13 held, then key 1 ----------------
        keys[3*4+3] = 1'b1;
        wait_flag(2'd1, 60, found);
        chk("k13_pulse_seen", found, 1);
        chk("k13_keyword", keyword, 4'd13);
        keys[0] = 1'b1;
        step(40, pulses, nz, lchg);
        chk("k13_k1_ignored", pulses, 0);
        chk("k13_keyword_kept", keyword, 4'd13);
        chk("k13_line_frozen", LINE, 4'b0111);
        keys[3*4+3] = 1'b0;
        wait_flag(2'd1, 80, found);
        chk("k1_pulse_seen", found, 1);
        chk("k1_keyword", keyword, 4'd1);
        keys = '0;
        wait_flag(2'd0, 30, found);
        chk("k1_released", found, 1);

        // ---------------- reset while key 9 held ----------------
        keys[2*4+2] = 1'b1;
        wait_flag(2'd1, 60, found);
        chk("k9_pulse_seen", found, 1);
        chk("k9_keyword", keyword, 4'd9);
        step(5, pulses, nz, lchg);
        chk("k9_held", flag_pressed, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("k9_rst_line", LINE, 4'b1110);
        chk("k9_rst_keyword", keyword, 4'd0);
        chk("k9_rst_flag", flag_pressed, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_flag(2'd1, 80, found);
        chk("k9_repulse_seen", found, 1);
        chk("k9_rekeyword", keyword, 4'd9);
        step(30, pulses, nz, lchg);
        chk("k9_single_repulse", pulses, 0);
        keys = '0;
        wait_flag(2'd0, 30, found);
        chk("k9_released", found, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
